// File: rtl/addsub_rr_scheduler_pkg.sv
// rtl/addsub_rr_scheduler_pkg.sv - shared tag type and ALU latency for the add/sub scheduler
package addsub_rr_scheduler_pkg;

  localparam int ALU_LAT   = 2;
  // Sized for the largest supported requester count (16).
  localparam int TAG_IDX_W = 4;

  typedef struct packed {
    logic                 valid;
    logic [TAG_IDX_W-1:0] idx;
  } tag_t;

endpackage

// File: rtl/addsub_rr_scheduler_rr_arbiter.sv
// rtl/addsub_rr_scheduler_rr_arbiter.sv - round-robin pick of one eligible requester from a pointer
module rr_arbiter #(
  parameter int N     = 4,
  parameter int PTR_W = $clog2(N)
) (
  input  logic [N-1:0]     eligible,
  input  logic [PTR_W-1:0] rr_ptr,
  output logic [N-1:0]     grant,
  output logic [PTR_W-1:0] grant_idx,
  output logic             grant_any
);

  int cand;

  // Walk upward from the pointer with wrap-around; the first eligible wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    cand      = 0;
    for (int k = 0; k < N; k++) begin
      cand = int'(rr_ptr) + k;
      if (cand >= N) cand = cand - N;
      if (!grant_any && eligible[cand[PTR_W-1:0]]) begin
        grant_any                 = 1'b1;
        grant[cand[PTR_W-1:0]]    = 1'b1;
        grant_idx                 = cand[PTR_W-1:0];
      end
    end
  end

endmodule

// File: rtl/addsub_rr_scheduler.sv
// rtl/addsub_rr_scheduler.sv - round-robin sharing of one external add/sub unit among requesters
module addsub_rr_scheduler
  import addsub_rr_scheduler_pkg::*;
#(
  parameter int WORD_WIDTH  = 32,
  parameter int REQ_COUNT   = 4,
  parameter int ALU_LATENCY = ALU_LAT
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic [REQ_COUNT-1:0]            req_valid,
  output logic [REQ_COUNT-1:0]            req_ready,
  input  logic [REQ_COUNT-1:0]            req_add_sub,
  input  logic [REQ_COUNT-1:0]            req_cin,
  input  logic [REQ_COUNT*WORD_WIDTH-1:0] req_dataa,
  input  logic [REQ_COUNT*WORD_WIDTH-1:0] req_datab,
  output logic                            alu_add_sub,
  output logic                            alu_cin,
  output logic [WORD_WIDTH-1:0]           alu_dataa,
  output logic [WORD_WIDTH-1:0]           alu_datab,
  input  logic                            alu_cout,
  input  logic [WORD_WIDTH-1:0]           alu_result,
  output logic [REQ_COUNT-1:0]            rsp_valid,
  output logic                            rsp_cout,
  output logic [WORD_WIDTH-1:0]           rsp_result
);

  localparam int PTR_W = $clog2(REQ_COUNT);

  logic [PTR_W-1:0]      rr_ptr;
  logic [REQ_COUNT-1:0]  pending;
  logic [REQ_COUNT-1:0]  eligible;
  logic [REQ_COUNT-1:0]  grant;
  logic [PTR_W-1:0]      grant_idx;
  logic                  grant_any;
  tag_t                  tag_pipe [ALU_LATENCY+1];
  tag_t                  exit_tag;
  logic                  sel_add_sub;
  logic                  sel_cin;
  logic [WORD_WIDTH-1:0] sel_a;
  logic [WORD_WIDTH-1:0] sel_b;

  // A requester with an op in flight is not eligible until its response retires.
  assign eligible = reset ? '0 : (req_valid & ~pending);

  rr_arbiter #(
    .N     (REQ_COUNT),
    .PTR_W (PTR_W)
  ) u_rr_arbiter (
    .eligible  (eligible),
    .rr_ptr    (rr_ptr),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_any (grant_any)
  );

  assign req_ready = grant;

  always_comb begin
    sel_add_sub = 1'b0;
    sel_cin     = 1'b0;
    sel_a       = '0;
    sel_b       = '0;
    for (int i = 0; i < REQ_COUNT; i++) begin
      if (grant[i]) begin
        sel_add_sub = sel_add_sub | req_add_sub[i];
        sel_cin     = sel_cin | req_cin[i];
        sel_a       = sel_a | req_dataa[i*WORD_WIDTH +: WORD_WIDTH];
        sel_b       = sel_b | req_datab[i*WORD_WIDTH +: WORD_WIDTH];
      end
    end
  end

  assign exit_tag = tag_pipe[ALU_LATENCY];

  always_comb begin
    rsp_valid  = '0;
    rsp_result = '0;
    rsp_cout   = 1'b0;
    if (!reset && exit_tag.valid) begin
      for (int i = 0; i < REQ_COUNT; i++) begin
        if (exit_tag.idx == TAG_IDX_W'(i)) rsp_valid[i] = 1'b1;
      end
      rsp_result = alu_result;
      rsp_cout   = alu_cout;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rr_ptr      <= '0;
      pending     <= '0;
      alu_add_sub <= 1'b0;
      alu_cin     <= 1'b0;
      alu_dataa   <= '0;
      alu_datab   <= '0;
      for (int s = 0; s <= ALU_LATENCY; s++) tag_pipe[s] <= '0;
    end else begin
      if (grant_any) begin
        rr_ptr      <= (grant_idx == PTR_W'(REQ_COUNT-1)) ? '0 : grant_idx + 1'b1;
        alu_add_sub <= sel_add_sub;
        alu_cin     <= sel_cin;
        alu_dataa   <= sel_a;
        alu_datab   <= sel_b;
      end
      pending     <= (pending | grant) & ~rsp_valid;
      tag_pipe[0] <= '{valid: grant_any, idx: TAG_IDX_W'(grant_idx)};
      for (int s = 1; s <= ALU_LATENCY; s++) tag_pipe[s] <= tag_pipe[s-1];
    end
  end

  // pending blocks a new grant, so set and clear never coincide on one bit.
  assert property (@(posedge clock) disable iff (reset) (grant & rsp_valid) == '0);

endmodule

// File: tb/tb_addsub_rr_scheduler.sv
// tb/tb_addsub_rr_scheduler.sv - scoreboard bench for addsub_rr_scheduler with an external ALU model
module tb_addsub_rr_scheduler;

  localparam int W = 32;
  localparam int N = 4;

  logic           clock = 1'b0;
  logic           reset;
  logic [N-1:0]   req_valid, req_ready, req_add_sub, req_cin, rsp_valid;
  logic [N*W-1:0] req_dataa, req_datab;
  logic           alu_add_sub, alu_cin, alu_cout, rsp_cout;
  logic [W-1:0]   alu_dataa, alu_datab, alu_result, rsp_result;
  logic [W-1:0]   v_a [N];
  logic [W-1:0]   v_b [N];

  typedef struct {
    int         idx;
    logic [W:0] val;
    int         due;
  } exp_t;

  exp_t       exp_q[$];
  int         errors = 0;
  int         checks = 0;
  int         cyc = 0;
  int         m_ptr = 0;
  int         busy_until [N];
  logic [W:0] alu_s1 = '0;
  logic [W:0] alu_s2 = '0;
  bit         last_grant = 0;
  bit         prev_reset = 0;
  logic       last_add, last_cin;
  logic [W-1:0] last_a, last_b;

  addsub_rr_scheduler #(.WORD_WIDTH(W), .REQ_COUNT(N), .ALU_LATENCY(2)) dut (
    .clock       (clock),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_add_sub (req_add_sub),
    .req_cin     (req_cin),
    .req_dataa   (req_dataa),
    .req_datab   (req_datab),
    .alu_add_sub (alu_add_sub),
    .alu_cin     (alu_cin),
    .alu_dataa   (alu_dataa),
    .alu_datab   (alu_datab),
    .alu_cout    (alu_cout),
    .alu_result  (alu_result),
    .rsp_valid   (rsp_valid),
    .rsp_cout    (rsp_cout),
    .rsp_result  (rsp_result)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc = cyc + 1;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      req_dataa[i*W +: W] = v_a[i];
      req_datab[i*W +: W] = v_b[i];
    end
  end

  // {cout, result}: add is a+b+cin, subtract is a+~b+cin (cout = no borrow).
  function automatic logic [W:0] ref_alu(input logic add, input logic cin,
                                         input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W:0] ext_cin;
    ext_cin = {{W{1'b0}}, cin};
    if (add) return {1'b0, a} + {1'b0, b} + ext_cin;
    return {1'b0, a} + {1'b0, ~b} + ext_cin;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // External two-stage add/sub unit fed by the DUT's issue registers.
  initial begin
    alu_result = '0;
    alu_cout   = 1'b0;
    forever begin
      @(posedge clock);
      #1;
      {alu_cout, alu_result} = alu_s2;
      alu_s2 = alu_s1;
      alu_s1 = ref_alu(alu_add_sub, alu_cin, alu_dataa, alu_datab);
    end
  end

  // Reference model: round-robin grant and per-requester busy window.
  initial begin
    logic [N-1:0] exp_grant;
    int gi;
    int i;
    for (int k = 0; k < N; k++) busy_until[k] = -1;
    forever begin
      @(negedge clock);
      exp_grant = '0;
      gi = 0;
      if (reset) begin
        exp_q.delete();
        m_ptr = 0;
        for (int k = 0; k < N; k++) busy_until[k] = -1;
        last_grant = 0;
        check("ready_in_reset", 64'(req_ready), 64'(0));
        if (prev_reset) check("alu_in_reset", {alu_add_sub, alu_cin, alu_dataa, alu_datab}, 64'(0));
        prev_reset = 1;
      end else begin
        prev_reset = 0;
        if (last_grant) begin
          check("alu_op", 64'({alu_add_sub, alu_cin}), 64'({last_add, last_cin}));
          check("alu_dataa", 64'(alu_dataa), 64'(last_a));
          check("alu_datab", 64'(alu_datab), 64'(last_b));
        end
        for (int k = 0; k < N; k++) begin
          i = (m_ptr + k) % N;
          if (exp_grant == '0 && req_valid[i] && cyc > busy_until[i]) begin
            exp_grant[i] = 1'b1;
            gi = i;
          end
        end
        check("req_ready", 64'(req_ready), 64'(exp_grant));
        last_grant = (exp_grant != '0);
        if (last_grant) begin
          last_add = req_add_sub[gi];
          last_cin = req_cin[gi];
          last_a   = v_a[gi];
          last_b   = v_b[gi];
          exp_q.push_back('{idx: gi, val: ref_alu(last_add, last_cin, last_a, last_b), due: cyc + 3});
          busy_until[gi] = cyc + 3;
          m_ptr = (gi + 1) % N;
        end
      end
    end
  end

  // Response monitor: pops the scoreboard whenever the DUT strobes a response.
  initial begin
    exp_t e;
    logic [N-1:0] exp_v;
    forever begin
      @(negedge clock);
      if (reset) begin
        check("rsp_in_reset", 64'(rsp_valid), 64'(0));
      end else if (rsp_valid != '0) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rsp_spurious: got rsp_valid %0h expected none (cycle %0d)", rsp_valid, cyc);
        end else begin
          e = exp_q.pop_front();
          exp_v = '0;
          exp_v[e.idx] = 1'b1;
          check("rsp_idx", 64'(rsp_valid), 64'(exp_v));
          check("rsp_result", 64'(rsp_result), 64'(e.val[W-1:0]));
          check("rsp_cout", 64'(rsp_cout), 64'(e.val[W]));
          check("rsp_cycle", 64'(cyc), 64'(e.due));
        end
      end else begin
        check("rsp_idle_payload", 64'({rsp_cout, rsp_result}), 64'(0));
        if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
          e = exp_q.pop_front();
          checks++;
          errors++;
          $display("FAIL rsp_missing: got no response expected idx %0d due cycle %0d (cycle %0d)", e.idx, e.due, cyc);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #2;
    end
  endtask

  task automatic randomize_fields();
    for (int i = 0; i < N; i++) begin
      v_a[i] = ($urandom_range(0, 7) == 0) ? '1 : W'($urandom);
      v_b[i] = ($urandom_range(0, 7) == 0) ? '1 : W'($urandom);
    end
    req_add_sub = N'($urandom);
    req_cin     = N'($urandom);
  endtask

  initial begin
    reset       = 1'b1;
    req_valid   = '0;
    req_add_sub = '0;
    req_cin     = '0;
    for (int i = 0; i < N; i++) begin
      v_a[i] = '0;
      v_b[i] = '0;
    end
    tick(3);
    reset = 1'b0;

    // Single add on requester 2: 5 + 3.
    req_add_sub = 4'b0100;
    req_cin     = 4'b0000;
    v_a[2] = 32'd5;
    v_b[2] = 32'd3;
    req_valid = 4'b0100;
    tick(1);
    req_valid = '0;
    tick(5);

    // Subtract on requester 0: 3 - 5 with cin=1.
    req_add_sub = 4'b0000;
    req_cin     = 4'b0001;
    v_a[0] = 32'd3;
    v_b[0] = 32'd5;
    req_valid = 4'b0001;
    tick(1);
    req_valid = '0;
    tick(5);

    // All requesters valid: one issue per cycle.
    req_valid = 4'b1111;
    for (int c = 0; c < 16; c++) begin
      randomize_fields();
      tick(1);
    end
    req_valid = '0;
    tick(5);

    // Requester 1 alone: issue every fourth cycle.
    req_valid = 4'b0010;
    for (int c = 0; c < 13; c++) begin
      randomize_fields();
      tick(1);
    end
    req_valid = '0;
    tick(5);

    // Reset in the cycle after a grant discards the in-flight op.
    req_valid = 4'b0001;
    tick(1);
    req_valid = '0;
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(5);

    // Pointer at 3 with requesters 0 and 3 valid: 3 first, then 0.
    req_valid = 4'b0100;
    tick(1);
    req_valid = '0;
    tick(5);
    req_valid = 4'b1001;
    tick(2);
    req_valid = '0;
    tick(5);

    // Random traffic.
    for (int c = 0; c < 3000; c++) begin
      randomize_fields();
      req_valid = N'($urandom);
      tick(1);
    end
    req_valid = '0;
    tick(6);

    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d outstanding expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
